// File: rtl/if_bpu_pkg.sv
// Shared decode constants, FSM encoding and helpers for the fetch-stage branch predictor.
package if_bpu_pkg;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam logic [4:0] LINK_RA = 5'd1;
    localparam logic [4:0] LINK_T0 = 5'd5;

    typedef enum logic {
        IDLE,
        WAIT_RS1
    } bpu_state_e;

    function automatic logic is_link(input logic [4:0] idx);
        return (idx == LINK_RA) || (idx == LINK_T0);
    endfunction
endpackage

// File: rtl/if_ras.sv
// Circular return-address stack: overflow overwrites the oldest entry, underflow pops are ignored.
module if_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW:0]     count;
    logic            do_pop;

    assign do_pop = pop && (count != '0);
    assign empty  = (count == '0);
    assign top    = stack[wptr - PW'(1)];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wptr  <= '0;
            count <= '0;
        end else if (push && !do_pop) begin
            wptr <= wptr + PW'(1);
            if (count != (PW+1)'(RAS_DEPTH))
                count <= count + (PW+1)'(1);
        end else if (do_pop && !push) begin
            wptr  <= wptr - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end

    // Pop+push collapses into an in-place overwrite of the top entry.
    always_ff @(posedge clk) begin
        if (rst_n && !clr && push) begin
            if (do_pop)
                stack[wptr - PW'(1)] <= wdata;
            else
                stack[wptr] <= wdata;
        end
    end
endmodule

// File: rtl/if_bpu.sv
// Fetch-stage static predictor: mini-decode, BTFN branches, RAS-backed returns, rs1 wait for jalr.
module if_bpu
    import if_bpu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    parameter bit BTFN_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            rs1_busy_i,
    output logic [4:0]      rf_rs1_idx_o,
    input  logic [XLEN-1:0] rf_rs1_rdata_i,
    input  logic            flush_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_pc_o
);
    bpu_state_e state, state_n;

    logic [6:0]        opcode;
    logic [4:0]        rd, rs1;
    logic              is_jal, is_jalr, is_br, rd_link, rs1_link;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   imm, pc4;
    logic [XLEN-1:0]   held_imm;
    logic [4:0]        held_rs1;

    logic              upd, taken_n;
    logic [XLEN-1:0]   target_n;
    logic              ras_push, ras_pop, ras_empty;
    logic [XLEN-1:0]   ras_top;

    assign opcode   = instr_i[6:0];
    assign rd       = instr_i[11:7];
    assign rs1      = instr_i[19:15];
    assign is_jal   = (opcode == OPC_JAL);
    assign is_jalr  = (opcode == OPC_JALR);
    assign is_br    = (opcode == OPC_BRANCH);
    assign rd_link  = is_link(rd);
    assign rs1_link = is_link(rs1);

    always_comb begin
        if (is_jal)
            imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        else if (is_br)
            imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        else
            imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
    end

    assign imm = XLEN'(imm32);
    assign pc4 = pc_i + XLEN'(4);

    assign if_ready_o   = (state == IDLE);
    assign rf_rs1_idx_o = (state == WAIT_RS1) ? held_rs1 : rs1;

    always_comb begin
        state_n  = state;
        upd      = 1'b0;
        taken_n  = 1'b0;
        target_n = pc4;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (flush_i) begin
            state_n = IDLE;
        end else if (state == WAIT_RS1) begin
            if (!rs1_busy_i) begin
                upd      = 1'b1;
                taken_n  = 1'b1;
                target_n = (rf_rs1_rdata_i + held_imm) & ~XLEN'(1);
                state_n  = IDLE;
            end
        end else if (if_valid_i) begin
            if (is_jal) begin
                upd      = 1'b1;
                taken_n  = 1'b1;
                target_n = pc_i + imm;
                ras_push = rd_link;
            end else if (is_br) begin
                upd      = 1'b1;
                taken_n  = BTFN_EN && imm[XLEN-1];
                target_n = taken_n ? pc_i + imm : pc4;
            end else if (is_jalr) begin
                ras_push = rd_link;
                // A call through the same link register keeps the current return address.
                ras_pop  = rs1_link && !(rd_link && rd == rs1);
                if (rs1_link && !ras_empty) begin
                    upd      = 1'b1;
                    taken_n  = 1'b1;
                    target_n = ras_top;
                end else if (rs1 == 5'd0) begin
                    upd      = 1'b1;
                    taken_n  = 1'b1;
                    target_n = imm & ~XLEN'(1);
                end else if (!rs1_busy_i) begin
                    upd      = 1'b1;
                    taken_n  = 1'b1;
                    target_n = (rf_rs1_rdata_i + imm) & ~XLEN'(1);
                end else begin
                    state_n = WAIT_RS1;
                end
            end else begin
                upd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            held_imm     <= '0;
            held_rs1     <= '0;
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_pc_o    <= '0;
        end else begin
            state        <= state_n;
            pred_valid_o <= upd;
            if (upd) begin
                pred_taken_o <= taken_n;
                pred_pc_o    <= target_n;
            end
            if (state == IDLE && state_n == WAIT_RS1) begin
                held_imm <= imm;
                held_rs1 <= rs1;
            end
        end
    end

    if_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush_i),
        .push  (ras_push),
        .pop   (ras_pop),
        .wdata (pc4),
        .top   (ras_top),
        .empty (ras_empty)
    );
endmodule

// File: tb/tb_if_bpu.sv
// Directed bench for if_bpu: an operation-level model (queue RAS, wait flag) checked every cycle.
module tb_if_bpu;
    localparam logic [1:0] K_OTHER = 2'd0, K_JAL = 2'd1, K_JALR = 2'd2, K_BR = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] imm;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] pc = '0;
    logic [31:0] instr = 32'h0000_0013;
    logic        rs1_busy = 1'b0;
    logic [4:0]  rf_rs1_idx;
    logic [31:0] rf_rs1_rdata = '0;
    logic        flush = 1'b0;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_pc;

    op_t cur;

    if_bpu #(.XLEN(32), .RAS_DEPTH(4), .BTFN_EN(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_valid_i     (if_valid),
        .if_ready_o     (if_ready),
        .pc_i           (pc),
        .instr_i        (instr),
        .rs1_busy_i     (rs1_busy),
        .rf_rs1_idx_o   (rf_rs1_idx),
        .rf_rs1_rdata_i (rf_rs1_rdata),
        .flush_i        (flush),
        .pred_valid_o   (pred_valid),
        .pred_taken_o   (pred_taken),
        .pred_pc_o      (pred_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] ras [$];
    logic        m_wait = 1'b0;
    logic [31:0] w_imm = '0;
    logic [4:0]  w_rs1 = '0;
    logic        e_valid = 1'b0, e_taken = 1'b0, rst_chk = 1'b0;
    logic [31:0] e_pc = '0;

    function automatic op_t mk(input logic [1:0] k, input logic [4:0] d, input logic [4:0] s,
                               input logic [31:0] i);
        op_t o;
        o.kind = k; o.rd = d; o.rs1 = s; o.imm = i;
        return o;
    endfunction

    function automatic logic [31:0] enc(input op_t o);
        logic [31:0] i;
        i = o.imm;
        case (o.kind)
            K_JAL:   return {i[20], i[10:1], i[11], i[19:12], o.rd, 7'h6F};
            K_JALR:  return {i[11:0], o.rs1, 3'b000, o.rd, 7'h67};
            K_BR:    return {i[12], i[10:5], 5'd0, 5'd0, 3'b000, i[4:1], i[11], 7'h63};
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic logic lnk(input logic [4:0] r);
        return r == 5'd1 || r == 5'd5;
    endfunction

    task automatic rpush(input logic [31:0] v);
        if (ras.size() == 4) void'(ras.pop_front());
        ras.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Evaluates what the DUT must show after the coming edge, from the current inputs.
    task automatic model_step();
        e_valid = 1'b0;
        rst_chk = 1'b0;
        if (!rst_n) begin
            e_taken = 1'b0; e_pc = '0; m_wait = 1'b0; ras.delete(); rst_chk = 1'b1;
        end else if (flush) begin
            m_wait = 1'b0; ras.delete();
        end else if (m_wait) begin
            if (!rs1_busy) begin
                e_valid = 1'b1; e_taken = 1'b1; e_pc = (rf_rs1_rdata + w_imm) & ~32'd1; m_wait = 1'b0;
            end
        end else if (if_valid) begin
            case (cur.kind)
                K_JAL: begin
                    e_valid = 1'b1; e_taken = 1'b1; e_pc = pc + cur.imm;
                    if (lnk(cur.rd)) rpush(pc + 32'd4);
                end
                K_BR: begin
                    e_valid = 1'b1;
                    e_taken = $signed(cur.imm) < 0;
                    e_pc    = e_taken ? pc + cur.imm : pc + 32'd4;
                end
                K_JALR: begin
                    if (lnk(cur.rs1) && ras.size() > 0) begin
                        e_valid = 1'b1; e_taken = 1'b1; e_pc = ras[ras.size()-1];
                    end else if (cur.rs1 == 5'd0) begin
                        e_valid = 1'b1; e_taken = 1'b1; e_pc = cur.imm & ~32'd1;
                    end else if (!rs1_busy) begin
                        e_valid = 1'b1; e_taken = 1'b1; e_pc = (rf_rs1_rdata + cur.imm) & ~32'd1;
                    end else begin
                        m_wait = 1'b1; w_imm = cur.imm; w_rs1 = cur.rs1;
                    end
                    if (lnk(cur.rs1) && !(lnk(cur.rd) && cur.rd == cur.rs1) && ras.size() > 0)
                        void'(ras.pop_back());
                    if (lnk(cur.rd)) rpush(pc + 32'd4);
                end
                default: begin
                    e_valid = 1'b1; e_taken = 1'b0; e_pc = pc + 32'd4;
                end
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("pred_valid", {31'd0, pred_valid}, {31'd0, e_valid});
        if (e_valid || rst_chk) begin
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_taken});
            chk("pred_pc", pred_pc, e_pc);
        end
        chk("if_ready", {31'd0, if_ready}, {31'd0, !m_wait});
        if (m_wait) chk("rs1_idx_held", {27'd0, rf_rs1_idx}, {27'd0, w_rs1});
    endtask

    task automatic run(input logic [31:0] p, input op_t o);
        pc = p; cur = o; instr = enc(o); if_valid = 1'b1;
        tick();
    endtask

    op_t nop, ret1, ret5;

    initial begin
        nop  = mk(K_OTHER, 5'd0, 5'd0, 32'd0);
        ret1 = mk(K_JALR, 5'd0, 5'd1, 32'd0);
        ret5 = mk(K_JALR, 5'd0, 5'd5, 32'd0);

        // Reset with a valid NOP presented
        rst_n = 1'b0;
        run(32'h0, nop);
        run(32'h0, nop);
        rst_n = 1'b1;
        run(32'h0, nop);
        chk("lit_nop_pc", pred_pc, 32'h4);

        // BTFN branches
        run(32'h100, mk(K_BR, 5'd0, 5'd0, -32'sd8));
        chk("lit_beq_back", pred_pc, 32'hF8);
        run(32'h100, mk(K_BR, 5'd0, 5'd0, 32'd16));
        chk("lit_beq_fwd", pred_pc, 32'h104);
        chk("lit_beq_fwd_nt", {31'd0, pred_taken}, 32'd0);

        // Call / return, then return on empty RAS reads the regfile
        run(32'h200, mk(K_JAL, 5'd1, 5'd0, 32'h40));
        chk("lit_jal", pred_pc, 32'h240);
        run(32'h300, ret1);
        chk("lit_ret", pred_pc, 32'h204);
        rf_rs1_rdata = 32'h5551;
        run(32'h304, ret1);
        chk("lit_ret_empty", pred_pc, 32'h5550);

        // Overflow: five calls, five returns
        for (int i = 0; i < 5; i++) run(32'h1000 + 32'h100 * i, mk(K_JAL, 5'd1, 5'd0, 32'h8));
        run(32'h2000, ret5); chk("lit_pop_a5", pred_pc, 32'h1404);
        run(32'h2004, ret5); chk("lit_pop_a4", pred_pc, 32'h1304);
        run(32'h2008, ret5); chk("lit_pop_a3", pred_pc, 32'h1204);
        run(32'h200C, ret5); chk("lit_pop_a2", pred_pc, 32'h1104);
        rf_rs1_rdata = 32'h7000;
        run(32'h2010, ret5); chk("lit_pop_under", pred_pc, 32'h7000);

        // Link replace (rd!=rs1) and push-only (rd==rs1)
        run(32'h3000, mk(K_JAL, 5'd1, 5'd0, 32'h20));
        run(32'h3100, mk(K_JALR, 5'd5, 5'd1, 32'd0));
        chk("lit_swap_tgt", pred_pc, 32'h3004);
        run(32'h3200, mk(K_JALR, 5'd1, 5'd1, 32'd0));
        chk("lit_same_tgt", pred_pc, 32'h3104);
        run(32'h3300, ret1); chk("lit_same_pop", pred_pc, 32'h3204);
        run(32'h3304, ret1); chk("lit_swap_pop", pred_pc, 32'h3104);
        run(32'h3308, mk(K_JALR, 5'd0, 5'd0, 32'h77)); chk("lit_jalr_x0", pred_pc, 32'h76);

        // Idle fetch slot
        if_valid = 1'b0;
        tick();

        // Wait for rs1: busy 3 cycles
        rf_rs1_rdata = 32'h1001;
        rs1_busy = 1'b1;
        run(32'h400, mk(K_JALR, 5'd0, 5'd7, 32'd4));
        chk("lit_wait_rdy1", {31'd0, if_ready}, 32'd0);
        tick();
        tick();
        chk("lit_wait_rdy3", {31'd0, if_ready}, 32'd0);
        rs1_busy = 1'b0;
        tick();
        chk("lit_wait_pc", pred_pc, 32'h1004);

        // Flush during WAIT_RS1
        rs1_busy = 1'b1;
        run(32'h480, mk(K_JALR, 5'd0, 5'd7, 32'd0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rs1_busy = 1'b0;
        chk("lit_flush_wait_rdy", {31'd0, if_ready}, 32'd1);

        // Flush clears stacked entries and kills a pushing call
        run(32'h500, mk(K_JAL, 5'd1, 5'd0, 32'h10));
        flush = 1'b1;
        run(32'h510, mk(K_JAL, 5'd5, 5'd0, 32'h10));
        flush = 1'b0;
        rf_rs1_rdata = 32'h8000;
        run(32'h600, ret1);
        chk("lit_flush_ras", pred_pc, 32'h8000);

        // Reset beats flush
        rst_n = 1'b0;
        flush = 1'b1;
        run(32'h700, mk(K_JAL, 5'd1, 5'd0, 32'h10));
        chk("lit_rst_pc", pred_pc, 32'h0);
        rst_n = 1'b1;
        flush = 1'b0;
        run(32'h704, ret1);
        chk("lit_post_rst", pred_pc, 32'h8000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
